// File: rtl/ds_pkg.sv
// ds_pkg: shared 1-Wire states, slot timing in microseconds and counter helpers
package ds_pkg;
  typedef enum logic [2:0] {IDLE, RST_LOW, RST_REL, WR_SLOT, RD_SLOT} state_t;
  localparam int CYC_PER_US = 25;
  localparam int T_RSTL_US = 480;
  localparam int T_PDS_US = 70;
  localparam int T_RSTH_US = 480;
  localparam int T_SLOT_US = 65;
  localparam int T_LOW1_US = 6;
  localparam int T_LOW0_US = 60;
  localparam int T_RDS_US = 12;
  localparam int CNT_W = 15;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t cycles_of(input int us);
    return cnt_t'(us * CYC_PER_US);
  endfunction
  function automatic cnt_t last_of(input int us);
    return cnt_t'(us * CYC_PER_US - 1);
  endfunction
endpackage

// File: rtl/ds_intf_bit_if.sv
// ds_intf_bit_if: bit-command handshake between the byte layer and the bit engine
interface ds_intf_bit_if;
  logic rst_en, wr_en, wdata, rd_en;
  logic rdata, rdata_vld, presence, pres_vld, rdy;
  modport master(output rst_en, wr_en, wdata, rd_en, input rdata, rdata_vld, presence, pres_vld, rdy);
  modport slave(input rst_en, wr_en, wdata, rd_en, output rdata, rdata_vld, presence, pres_vld, rdy);
endinterface

// File: rtl/ds_sync2.sv
// ds_sync2: two-flop synchroniser for the asynchronous DQ pin
module ds_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] s;
  // resets to the idle-high level of the pulled-up bus
  always_ff @(posedge clk)
    if (rst) s <= 2'b11;
    else s <= {s[0], d};
  assign q = s[1];
endmodule

// File: rtl/ds_intf_bit.sv
// ds_intf_bit: 1-Wire bit timing engine (reset/presence, write slot, read slot)
module ds_intf_bit
  import ds_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ds_intf_bit_if.slave bus,
  input  logic dq_in,
  output logic dq_oe
);
  state_t state, state_n;
  cnt_t cnt;
  logic dq_sync, wbit, done;
  ds_sync2 u_sync (.clk(clk), .rst(rst), .d(dq_in), .q(dq_sync));
  // last cycle of the current phase
  always_comb
    done = (state == RST_LOW && cnt == last_of(T_RSTL_US)) ||
           (state == RST_REL && cnt == last_of(T_RSTH_US)) ||
           ((state == WR_SLOT || state == RD_SLOT) && cnt == last_of(T_SLOT_US));
  // next state: accept in IDLE with rst_en > wr_en > rd_en, leave a phase on its last cycle
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = bus.rst_en ? RST_LOW : bus.wr_en ? WR_SLOT : bus.rd_en ? RD_SLOT : IDLE;
    else if (done)
      state_n = (state == RST_LOW) ? RST_REL : IDLE;
  end
  // DQ drive, handshake and completion pulses decoded from state and counter
  always_comb begin
    dq_oe = (state == RST_LOW) ||
            (state == WR_SLOT && cnt < (wbit ? cycles_of(T_LOW1_US) : cycles_of(T_LOW0_US))) ||
            (state == RD_SLOT && cnt < cycles_of(T_LOW1_US));
    bus.rdy = state == IDLE;
    bus.pres_vld = state == RST_REL && done;
    bus.rdata_vld = state == RD_SLOT && done;
  end
  // state, phase counter, latched write bit and the sampled results
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wbit <= 1'b0;
      bus.rdata <= 1'b0;
      bus.presence <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + cnt_t'(1);
      if (state == IDLE && state_n == WR_SLOT) wbit <= bus.wdata;
      if (state == RST_REL && cnt == last_of(T_PDS_US)) bus.presence <= ~dq_sync;
      if (state == RD_SLOT && cnt == last_of(T_RDS_US)) bus.rdata <= dq_sync;
    end
endmodule

// File: tb/tb_ds_intf_bit.sv
// tb_ds_intf_bit: randomized checks of the 1-Wire bit engine against slot-level expectations
module tb_ds_intf_bit;
  localparam int CPU = 25;
  localparam int RSTL = 480 * CPU;
  localparam int RSTH = 480 * CPU;
  localparam int SLOT = 65 * CPU;
  localparam int LOW1 = 6 * CPU;
  localparam int LOW0 = 60 * CPU;
  typedef struct packed {logic oe, rdy, rv, pv, rdata, pres;} obs_t;
  logic clk = 1'b0, rst = 1'b1, dq_in, dq_oe;
  int cyc = 0, base = 0, lo = 0, hi = 0;
  int vectors = 0, miscompares = 0;
  logic pres_exp = 1'b0;
  obs_t tr[$];
  ds_intf_bit_if bus ();
  ds_intf_bit dut (.clk(clk), .rst(rst), .bus(bus), .dq_in(dq_in), .dq_oe(dq_oe));
  always #20 clk = ~clk;
  always @(posedge clk) cyc++;
  assign dq_in = !(dq_oe || (cyc - base >= lo && cyc - base < hi));

  task automatic issue(input logic r, input logic w, input logic d, input logic rd);
    bus.rst_en = r; bus.wr_en = w; bus.wdata = d; bus.rd_en = rd;
    base = cyc + 1;
    @(posedge clk); #1;
    bus.rst_en = 0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = 1'($urandom);
  endtask

  task automatic capture(input int n, input int inj);
    tr.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == inj) bus.wr_en = 1'b1;
      else if (i == inj + 1) bus.wr_en = 1'b0;
      tr.push_back('{dq_oe, bus.rdy, bus.rdata_vld, bus.pres_vld, bus.rdata, bus.presence});
    end
  endtask

  task automatic scan(output int lead, output int ones, output int npv, output int pv_at,
                      output int nrv, output int rv_at, output int nrdy);
    lead = 0; ones = 0; npv = 0; pv_at = -1; nrv = 0; rv_at = -1; nrdy = 0;
    for (int i = 0; i < tr.size() - 1; i++) begin
      if (tr[i].oe) ones++;
      if (tr[i].oe && lead == i) lead++;
      if (tr[i].pv) begin npv++; pv_at = i; end
      if (tr[i].rv) begin nrv++; rv_at = i; end
      if (tr[i].rdy) nrdy++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.rdy, dq_oe, bus.rdata_vld, bus.pres_vld, bus.rdata, bus.presence} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 100000", {bus.rdy, dq_oe, bus.rdata_vld, bus.pres_vld, bus.rdata, bus.presence});
    end
  endtask

  task automatic check_reset_seq(input string name, input logic present);
    int lead, ones, npv, pv_at, nrv, rv_at, nrdy;
    capture(RSTL + RSTH + 1, -1);
    scan(lead, ones, npv, pv_at, nrv, rv_at, nrdy);
    pres_exp = present;
    vectors++;
    if (lead != RSTL || ones != RSTL) begin
      miscompares++;
      $display("FAIL %s_low: got lead %0d total %0d expected %0d", name, lead, ones, RSTL);
    end
    vectors++;
    if (npv != 1 || pv_at != RSTL + RSTH - 1) begin
      miscompares++;
      $display("FAIL %s_pres_vld: got %0d pulses at %0d expected 1 at %0d", name, npv, pv_at, RSTL + RSTH - 1);
    end
    vectors++;
    if (tr[RSTL + RSTH - 1].pres !== present) begin
      miscompares++;
      $display("FAIL %s_presence: got %b expected %b", name, tr[RSTL + RSTH - 1].pres, present);
    end
    vectors++;
    if (nrv != 0 || nrdy != 0 || tr[RSTL + RSTH].rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_rdy: got rdata_vld %0d busy-rdy %0d final rdy %b expected 0 0 1", name, nrv, nrdy, tr[RSTL + RSTH].rdy);
    end
  endtask

  task automatic test_reset_present;
    lo = RSTL + $urandom_range(15, 30) * CPU;
    hi = RSTL + $urandom_range(120, 200) * CPU;
    issue(1, 0, 0, 0);
    check_reset_seq("reset_dev", 1'b1);
    lo = 0; hi = 0;
  endtask

  task automatic test_simultaneous;
    lo = 0; hi = 0;
    issue(1, 1, 1'($urandom), 1);
    check_reset_seq("simul_nodev", 1'b0);
  endtask

  task automatic test_write_b2b;
    int lead, ones, npv, pv_at, nrv, rv_at, nrdy;
    logic b;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom);
      issue(0, 1, b, 0);
      capture(SLOT + 1, -1);
      scan(lead, ones, npv, pv_at, nrv, rv_at, nrdy);
      vectors++;
      if (lead != (b ? LOW1 : LOW0) || ones != lead) begin
        miscompares++;
        $display("FAIL write%0d_low: got lead %0d total %0d expected %0d", k, lead, ones, b ? LOW1 : LOW0);
      end
      vectors++;
      if (nrdy != 0 || tr[SLOT].rdy !== 1'b1 || npv != 0 || nrv != 0) begin
        miscompares++;
        $display("FAIL write%0d_slot: got busy-rdy %0d end rdy %b pulses %0d/%0d expected 0 1 0/0", k, nrdy, tr[SLOT].rdy, npv, nrv);
      end
    end
  endtask

  task automatic do_read(input string name, input logic b, input int inj);
    int lead, ones, npv, pv_at, nrv, rv_at, nrdy;
    lo = 0;
    hi = b ? 0 : $urandom_range(20, 45) * CPU;
    issue(0, 0, 0, 1);
    capture(SLOT + 1, inj);
    hi = 0;
    scan(lead, ones, npv, pv_at, nrv, rv_at, nrdy);
    vectors++;
    if (nrv != 1 || rv_at != SLOT - 1 || tr[SLOT - 1].rdata !== b) begin
      miscompares++;
      $display("FAIL %s_data: got %0d pulses at %0d rdata %b expected 1 at %0d rdata %b", name, nrv, rv_at, tr[SLOT - 1].rdata, SLOT - 1, b);
    end
    vectors++;
    if (lead != LOW1 || ones != LOW1 || nrdy != 0 || tr[SLOT].rdy !== 1'b1 || npv != 0) begin
      miscompares++;
      $display("FAIL %s_slot: got low %0d/%0d busy-rdy %0d end rdy %b pres_vld %0d expected %0d 0 1 0", name, lead, ones, nrdy, tr[SLOT].rdy, npv, LOW1);
    end
    vectors++;
    if (tr[SLOT].rdata !== b || tr[SLOT].pres !== pres_exp) begin
      miscompares++;
      $display("FAIL %s_hold: got rdata %b presence %b expected %b %b", name, tr[SLOT].rdata, tr[SLOT].pres, b, pres_exp);
    end
  endtask

  task automatic test_read;
    for (int k = 0; k < 4; k++)
      do_read($sformatf("read%0d", k), (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom), -1);
  endtask

  task automatic test_ignored;
    int lead, ones, npv, pv_at, nrv, rv_at, nrdy;
    do_read("ignored_rd", 1'($urandom), $urandom_range(10, SLOT - 30));
    capture(60, -1);
    scan(lead, ones, npv, pv_at, nrv, rv_at, nrdy);
    vectors++;
    if (ones != 0 || nrdy != 59 || npv != 0 || nrv != 0) begin
      miscompares++;
      $display("FAIL ignored_wr: got dq_oe cycles %0d idle-rdy %0d pulses %0d/%0d expected 0 59 0/0", ones, nrdy, npv, nrv);
    end
  endtask

  task automatic test_abort;
    int lead, ones, npv, pv_at, nrv, rv_at, nrdy;
    issue(0, 1, 0, 0);
    capture(500, -1);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dq_oe, bus.rdy, bus.rdata_vld, bus.pres_vld} !== 4'b0100) begin
      miscompares++;
      $display("FAIL abort_state: got oe/rdy/rv/pv %b expected 0100", {dq_oe, bus.rdy, bus.rdata_vld, bus.pres_vld});
    end
    rst = 1'b0;
    pres_exp = 1'b0;
    capture(20, -1);
    scan(lead, ones, npv, pv_at, nrv, rv_at, nrdy);
    vectors++;
    if (ones != 0 || nrdy != 19 || npv != 0 || nrv != 0) begin
      miscompares++;
      $display("FAIL abort_idle: got dq_oe cycles %0d rdy %0d pulses %0d/%0d expected 0 19 0/0", ones, nrdy, npv, nrv);
    end
    do_read("abort_rd", 1'($urandom), -1);
  endtask

  initial begin
    bus.rst_en = 0; bus.wr_en = 0; bus.wdata = 0; bus.rd_en = 0;
    test_reset();
    test_reset_present();
    test_simultaneous();
    test_write_b2b();
    test_read();
    test_ignored();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(40 * 95000);
    $display("FAIL timeout: simulation did not complete within the cycle budget");
    $fatal(1, "timeout");
  end
endmodule
